// File: rtl/fb_line_pixel_unpacker.sv
// Pixel-clock unpacker: reads 2-pixel words from the line BRAM, emits aligned RGB/DE/sync
// and issues line-fill requests. Build with FBREADER_UNDERRUN_DETECT_EN to flag and paint underrun lines.
module fb_line_pixel_unpacker #(
    parameter int          H_ACTIVE       = 640,
    parameter int          H_TOTAL        = 800,
    parameter int          V_ACTIVE       = 480,
    parameter int          V_TOTAL        = 525,
    parameter logic [23:0] UNDERRUN_COLOR = 24'hFF00FF
) (
    input  logic        clk_25m,
    input  logic        reset,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        fb_sel,
    output logic [9:0]  bram_addr,
    input  logic [63:0] bram_dout,
    output logic        line_req,
    output logic [9:0]  line_req_row,
    output logic        line_req_fb,
    input  logic        line_done,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        underrun
);

    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] H_TOT      = 10'(H_TOTAL);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] V_TOT      = 10'(V_TOTAL);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);

    // Even column lives in the low 32 bits, odd column in the high 32 bits.
    function automatic logic [23:0] pick_rgb(input logic [63:0] word, input logic odd);
        return odd ? word[63:40] : word[31:8];
    endfunction

    logic       act_in;
    logic       req_fire;
    logic [9:0] req_row;
    logic [1:0] bank_ready;
    logic [1:0] bank_ready_nxt;
    logic       last_bank;
    logic       fb_cur;
    logic       unused_bits;

    logic act_p1, hc0_p1, hs_p1, vs_p1;
    logic act_p2, hc0_p2, hs_p2, vs_p2;

    assign act_in = (hc < H_ACT) && (hc < H_TOT) && (vc < V_ACT) && (vc < V_TOT);

    always_comb begin
        req_fire = 1'b0;
        req_row  = '0;
        if (hc == H_ACT) begin
            if (vc < V_ACT_LAST) begin
                req_fire = 1'b1;
                req_row  = vc + 10'd1;
            end else if (vc == V_LAST) begin
                req_fire = 1'b1;
                req_row  = '0;
            end
        end
    end

    // A request clearing a bank overrides a completion for it in the same cycle.
    always_comb begin
        bank_ready_nxt = bank_ready;
        if (line_done)
            bank_ready_nxt[last_bank] = 1'b1;
        if (req_fire)
            bank_ready_nxt[req_row[0]] = 1'b0;
    end

    always_ff @(posedge clk_25m) begin
        if (reset) begin
            line_req     <= 1'b0;
            line_req_row <= '0;
            line_req_fb  <= 1'b0;
            fb_cur       <= 1'b0;
            bank_ready   <= '0;
            last_bank    <= 1'b0;
        end else begin
            line_req   <= req_fire;
            bank_ready <= bank_ready_nxt;
            if (hc == 10'd0 && vc == V_LAST)
                fb_cur <= fb_sel;
            if (req_fire) begin
                line_req_row <= req_row;
                line_req_fb  <= fb_cur;
                last_bank    <= req_row[0];
            end
        end
    end

`ifdef FBREADER_UNDERRUN_DETECT_EN
    logic row_act;
    logic row_start;
    logic ur_line;
    logic ur_p1;
    logic ur_p2;

    assign row_act   = (vc < V_ACT) && (vc < V_TOT);
    assign row_start = (hc == 10'd0) && row_act;
    assign unused_bits = ^{bram_dout[7:0], bram_dout[39:32]};

    always_ff @(posedge clk_25m) begin
        if (reset) begin
            ur_line  <= 1'b0;
            ur_p1    <= 1'b0;
            ur_p2    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            // Stage 1: the row's verdict is taken once, at its first column
            if (row_start)
                ur_line <= ~bank_ready[vc[0]];
            ur_p1 <= row_start ? ~bank_ready[vc[0]] : ur_line;
            // Stage 2
            ur_p2 <= ur_p1;
            // Stage 3
            if (ur_p2 && act_p2)
                underrun <= 1'b1;
        end
    end
`else
    assign unused_bits = ^{bram_dout[7:0], bram_dout[39:32], bank_ready, UNDERRUN_COLOR};
    assign underrun    = 1'b0;
`endif

    always_ff @(posedge clk_25m) begin
        if (reset) begin
            bram_addr <= '0;
            act_p1 <= 1'b0; hc0_p1 <= 1'b0; hs_p1 <= 1'b0; vs_p1 <= 1'b0;
            act_p2 <= 1'b0; hc0_p2 <= 1'b0; hs_p2 <= 1'b0; vs_p2 <= 1'b0;
            de     <= 1'b0;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            {red, green, blue} <= '0;
        end else begin
            // Stage 1: address issue; the address is held through blanking
            if (act_in)
                bram_addr <= {vc[0], hc[9:1]};
            act_p1 <= act_in;
            hc0_p1 <= hc[0];
            hs_p1  <= hsync_in;
            vs_p1  <= vsync_in;
            // Stage 2: BRAM read in flight
            act_p2 <= act_p1;
            hc0_p2 <= hc0_p1;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            // Stage 3: output register
            de    <= act_p2;
            hsync <= hs_p2;
            vsync <= vs_p2;
            if (!act_p2)
                {red, green, blue} <= '0;
`ifdef FBREADER_UNDERRUN_DETECT_EN
            else if (ur_p2)
                {red, green, blue} <= UNDERRUN_COLOR;
`endif
            else
                {red, green, blue} <= pick_rgb(bram_dout, hc0_p2);
        end
    end

endmodule

// File: tb/tb_fb_line_pixel_unpacker.sv
// Bench for fb_line_pixel_unpacker: line-level reference model plus directed literal checks.
module tb_fb_line_pixel_unpacker;

    localparam logic [23:0] UR_COLOR = 24'hFF00FF;

    logic        clk_25m = 1'b0;
    logic        reset;
    logic [9:0]  hc, vc;
    logic        hsync_in, vsync_in, fb_sel;
    logic [9:0]  bram_addr;
    logic [63:0] bram_dout;
    logic        line_req;
    logic [9:0]  line_req_row;
    logic        line_req_fb;
    logic        line_done;
    logic [7:0]  red, green, blue;
    logic        de, hsync, vsync, underrun;

    always #20 clk_25m = ~clk_25m;

    fb_line_pixel_unpacker dut (
        .clk_25m(clk_25m), .reset(reset), .hc(hc), .vc(vc),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .fb_sel(fb_sel),
        .bram_addr(bram_addr), .bram_dout(bram_dout),
        .line_req(line_req), .line_req_row(line_req_row), .line_req_fb(line_req_fb),
        .line_done(line_done), .red(red), .green(green), .blue(blue),
        .de(de), .hsync(hsync), .vsync(vsync), .underrun(underrun)
    );

    logic [63:0] mem [0:1023];
    always @(posedge clk_25m) bram_dout <= mem[bram_addr];

    int n_checks = 0;
    int n_fail   = 0;
    int bank_row [2];
    int done_bank = 0;
    bit cmp_en = 1'b0;
    int n_pulses = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (vc=%0d hc=%0d)", nm, act, exp, vc, hc);
        end
    endtask

    function automatic logic [31:0] pix(input int col, input int row);
        return 32'((col | (row << 12)) << 8);
    endfunction

    function automatic logic [23:0] exp_rgb(input int col, input int row);
        logic [31:0] p;
        if (row < 0) return 24'h0;
        p = pix(col, row);
        return p[31:8];
    endfunction

    typedef struct packed {
        logic        de;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        und;
    } ent_t;

    ent_t       m1, m2, m3;
    logic [1:0] m_ready;
    logic       m_fb, m_ur_row, m_sticky, m_req, m_rfb;
    logic [9:0] m_row, m_addr;

    // Reference model: what each sampled (hc, vc) must produce three clocks later.
    initial begin
        ent_t e;
        bit   act;
        int   h, v;
        forever begin
            @(posedge clk_25m);
            if (reset === 1'b1) begin
                m1 = '0; m2 = '0; m3 = '0;
                m_ready = '0; m_fb = 0; m_ur_row = 0; m_sticky = 0;
                m_req = 0; m_row = '0; m_rfb = 0; m_addr = '0;
            end else begin
                h = int'(hc);
                v = int'(vc);
                act = (h < 640) && (v < 480);
                if (h == 0 && v < 480) begin
                    m_ur_row = !m_ready[v % 2];
`ifdef FBREADER_UNDERRUN_DETECT_EN
                    if (m_ur_row) m_sticky = 1'b1;
`endif
                end
                e.de = act;
                e.hs = hsync_in;
                e.vs = vsync_in;
`ifdef FBREADER_UNDERRUN_DETECT_EN
                e.und = m_sticky;
                e.rgb = !act ? 24'h0 : (m_ur_row ? UR_COLOR : exp_rgb(h, bank_row[v % 2]));
`else
                e.und = 1'b0;
                e.rgb = !act ? 24'h0 : exp_rgb(h, bank_row[v % 2]);
`endif
                if (act) m_addr = 10'(((v % 2) << 9) | (h / 2));
                if (h == 0 && v == 524) m_fb = fb_sel;
                if (line_done === 1'b1) m_ready[done_bank] = 1'b1;
                m_req = 1'b0;
                if (h == 640 && v < 479) begin
                    m_req = 1'b1; m_row = 10'(v + 1);
                end else if (h == 640 && v == 524) begin
                    m_req = 1'b1; m_row = 10'd0;
                end
                if (m_req) begin
                    m_rfb = m_fb;
                    m_ready[m_row[0]] = 1'b0;
                end
                m3 = m2; m2 = m1; m1 = e;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_25m);
            if (cmp_en) begin
                check("de", 32'(de), 32'(m3.de));
                check("rgb", 32'({red, green, blue}), 32'(m3.rgb));
                check("hsync", 32'(hsync), 32'(m3.hs));
                check("vsync", 32'(vsync), 32'(m3.vs));
                check("underrun", 32'(underrun), 32'(m3.und));
                check("line_req", 32'(line_req), 32'(m_req));
                check("line_req_row", 32'(line_req_row), 32'(m_row));
                check("line_req_fb", 32'(line_req_fb), 32'(m_rfb));
                check("bram_addr", 32'(bram_addr), 32'(m_addr));
            end
        end
    end

    // Reader stand-in: fills the requested bank some cycles later; row 6 is never delivered.
    initial begin
        int row;
        line_done = 1'b0;
        forever begin
            @(negedge clk_25m);
            if (line_req === 1'b1) begin
                row = int'(line_req_row);
                repeat (20) @(negedge clk_25m);
                if (row != 6) begin
                    for (int w = 0; w < 320; w++)
                        mem[((row % 2) << 9) | w] = {pix(2 * w + 1, row), pix(2 * w, row)};
                    bank_row[row % 2] = row;
                    done_bank = row % 2;
                    line_done = 1'b1;
                    @(negedge clk_25m);
                    line_done = 1'b0;
                end
            end
        end
    end

    task automatic lit(input int v, input int h);
        if (v == 3 && h == 6) check("addr_v3_h5", 32'(bram_addr), 32'h202);
        if (v == 3 && h == 8) begin
            check("de_v3_h5", 32'(de), 32'd1);
            check("rgb_v3_h5", 32'({red, green, blue}), 32'h003005);
        end
        if (v == 10 && h == 641) begin
            check("req_v10", 32'(line_req), 32'd1);
            check("req_row_v10", 32'(line_req_row), 32'd11);
        end
        if (v == 10 && h == 658) check("hsync_before", 32'(hsync), 32'd1);
        if (v == 10 && h == 659) check("hsync_after", 32'(hsync), 32'd0);
        if (v == 10 && h == 700) begin
            check("blank_de", 32'(de), 32'd0);
            check("blank_rgb", 32'({red, green, blue}), 32'd0);
        end
        if (v == 6 && h == 2) check("ur_pre", 32'(underrun), 32'd0);
        if (v == 6 && h == 3) begin
`ifdef FBREADER_UNDERRUN_DETECT_EN
            check("ur_rise", 32'(underrun), 32'd1);
            check("ur_color", 32'({red, green, blue}), 32'hFF00FF);
`else
            check("ur_off", 32'(underrun), 32'd0);
            check("stale_rgb", 32'({red, green, blue}), 32'h004000);
`endif
        end
        if (v == 7 && h == 3) begin
            check("row7_rgb", 32'({red, green, blue}), 32'h007000);
`ifdef FBREADER_UNDERRUN_DETECT_EN
            check("ur_sticky", 32'(underrun), 32'd1);
`endif
        end
        if (v == 101 && h == 641) begin
            check("req_row_v101", 32'(line_req_row), 32'd102);
            check("req_fb_v101", 32'(line_req_fb), 32'd0);
        end
        if (v == 200 && h == 301) begin
            check("rst_de", 32'(de), 32'd0);
            check("rst_rgb", 32'({red, green, blue}), 32'd0);
            check("rst_hsync", 32'(hsync), 32'd0);
            check("rst_vsync", 32'(vsync), 32'd0);
            check("rst_req", 32'(line_req), 32'd0);
            check("rst_row", 32'(line_req_row), 32'd0);
            check("rst_addr", 32'(bram_addr), 32'd0);
            check("rst_ur", 32'(underrun), 32'd0);
        end
        if (v == 200 && h == 641) begin
            check("req_after_rst", 32'(line_req), 32'd1);
            check("row_after_rst", 32'(line_req_row), 32'd201);
        end
    endtask

    task automatic run_line(input int v, input int rst_at);
        n_pulses = 0;
        for (int h = 0; h < 800; h++) begin
            @(posedge clk_25m);
            #1;
            hc       = 10'(h);
            vc       = 10'(v);
            hsync_in = !(h >= 656 && h < 752);
            vsync_in = !(v >= 490 && v < 492);
            reset    = (h == rst_at || h == rst_at + 1);
            if (v == 100 && h == 0) fb_sel = 1'b1;
            @(negedge clk_25m);
            if (line_req === 1'b1) n_pulses++;
            lit(v, h);
        end
    endtask

    initial begin
        reset = 1'b1; hc = 10'd799; vc = 10'd523;
        hsync_in = 1'b1; vsync_in = 1'b1; fb_sel = 1'b0;
        bank_row[0] = -1; bank_row[1] = -1;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(posedge clk_25m);
        @(negedge clk_25m);
        check("init_de", 32'(de), 32'd0);
        check("init_hsync", 32'(hsync), 32'd0);
        check("init_req", 32'(line_req), 32'd0);
        check("init_ur", 32'(underrun), 32'd0);
        check("init_addr", 32'(bram_addr), 32'd0);
        cmp_en = 1'b1;
        @(posedge clk_25m);
        #1 reset = 1'b0;

        run_line(524, -10);
        check("f0_row", 32'(line_req_row), 32'd0);
        check("f0_fb", 32'(line_req_fb), 32'd0);
        for (int v = 0; v < 12; v++) begin
            run_line(v, -10);
            if (v == 10) check("pulses_v10", 32'(n_pulses), 32'd1);
        end
        run_line(99, -10);
        run_line(100, -10);
        run_line(101, -10);
        run_line(102, -10);
        run_line(200, 300);
        run_line(201, -10);
        run_line(478, -10);
        check("row_v478", 32'(line_req_row), 32'd479);
        check("fb_v478", 32'(line_req_fb), 32'd0);
        run_line(479, -10);
        check("pulses_v479", 32'(n_pulses), 32'd0);
        run_line(480, -10);
        run_line(524, -10);
        check("f1_row", 32'(line_req_row), 32'd0);
        check("f1_fb", 32'(line_req_fb), 32'd1);
        check("pulses_v524", 32'(n_pulses), 32'd1);
        run_line(0, -10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
